// File: rtl/frag_div_unit.sv
// Iterative radix-2 restoring divide/remainder unit (RV32M semantics) with a
// start/busy/done handshake; one quotient bit per cycle, MSB first.
module frag_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      ALU_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);

    state_t          state;
    logic            is_rem;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] rem;
    logic [CW-1:0]   count;

    logic            accept;
    logic            req_signed;
    logic            req_rem;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] special_res;

    // ALU_ctrl[0] = unsigned, ALU_ctrl[1] = remainder within the 4'b11xx group.
    assign accept     = (state == IDLE || state == DONE) && start && (ALU_ctrl[3:2] == 2'b11);
    assign req_signed = ~ALU_ctrl[0];
    assign req_rem    = ALU_ctrl[1];
    assign sign_a     = req_signed & src_a[XLEN-1];
    assign sign_b     = req_signed & src_b[XLEN-1];
    assign mag_a      = sign_a ? -src_a : src_a;
    assign mag_b      = sign_b ? -src_b : src_b;
    assign div_zero   = (src_b == '0);
    assign overflow   = req_signed && (src_a == MIN_NEG) && (src_b == ALL_ONES);
    assign special_res = div_zero ? (req_rem ? src_a : ALL_ONES)
                                  : (req_rem ? '0    : MIN_NEG);

    // Trial subtraction: the extra top bit of diff is the borrow.
    logic [XLEN:0]   pr;
    logic [XLEN:0]   diff;
    logic            fits;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    assign pr    = {rem, quo[XLEN-1]};
    assign diff  = pr - {1'b0, dvs};
    assign fits  = ~diff[XLEN];
    assign q_fix = neg_q ? -quo : quo;
    assign r_fix = neg_r ? -rem : rem;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            quo    <= '0;
            dvs    <= '0;
            rem    <= '0;
            count  <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (accept) begin
                            is_rem <= req_rem;
                            neg_q  <= sign_a ^ sign_b;
                            neg_r  <= sign_a;
                            if (div_zero || overflow) begin
                                result <= special_res;
                                state  <= DONE;
                                done   <= 1'b1;
                                busy   <= 1'b0;
                            end else begin
                                quo   <= mag_a;
                                dvs   <= mag_b;
                                rem   <= '0;
                                count <= '0;
                                state <= CALC;
                                busy  <= 1'b1;
                            end
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    CALC: begin
                        rem   <= fits ? diff[XLEN-1:0] : pr[XLEN-1:0];
                        quo   <= {quo[XLEN-2:0], fits};
                        count <= count + 1'b1;
                        if (count == LAST_STEP) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        result <= is_rem ? r_fix : q_fix;
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frag_div_unit.sv
// Directed self-checking bench for frag_div_unit: latency, results, special
// cases, back-to-back issue, ignored requests, flush and asynchronous reset.
module tb_frag_div_unit;

    localparam logic [3:0] CTRL_DIV  = 4'b1100;
    localparam logic [3:0] CTRL_DIVU = 4'b1101;
    localparam logic [3:0] CTRL_REM  = 4'b1110;
    localparam logic [3:0] CTRL_REMU = 4'b1111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  ALU_ctrl = 4'b0000;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    frag_div_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ALU_ctrl (ALU_ctrl),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; start is held for exactly one rising edge.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        ALU_ctrl = c;
        src_a    = a;
        src_b    = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // lat = falling edges counted from the acceptance edge (1 = first one after it).
    task automatic wait_done(output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int n = 1; n <= 100; n++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int exp_busy);
        int lat;
        int bcnt;
        issue(c, a, b);
        wait_done(lat, bcnt);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, bcnt, exp_busy);
        check({tag, "_res"}, result, exp_res);
    endtask

    // Watches a window of cycles and counts cycles with done / busy high.
    task automatic watch(input int cycles, output int ndone, output int nbusy);
        ndone = 0;
        nbusy = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy) nbusy++;
        end
    endtask

    initial begin
        int ndone;
        int nbusy;
        int first;
        logic [31:0] seen;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("divu_100_7", CTRL_DIVU, 32'd100, 32'd7, 32'd14, 34, 33);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
        run_op("remu_100_7", CTRL_REMU, 32'd100, 32'd7, 32'd2, 34, 33);
        @(negedge clk);
        run_op("div_m7_2", CTRL_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 33);
        @(negedge clk);
        run_op("rem_m7_2", CTRL_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 33);
        @(negedge clk);
        run_op("div_7_m2", CTRL_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 33);
        @(negedge clk);
        run_op("rem_7_m2", CTRL_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 33);
        @(negedge clk);
        run_op("divu_max_1", CTRL_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 33);
        @(negedge clk);

        run_op("divu_5_0", CTRL_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        @(negedge clk);
        run_op("rem_5_0", CTRL_REM, 32'd5, 32'd0, 32'd5, 1, 0);
        @(negedge clk);
        run_op("div_ovf", CTRL_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        @(negedge clk);
        run_op("rem_ovf", CTRL_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
        @(negedge clk);

        // Second request issued in the first operation's DONE cycle.
        run_op("b2b_div_20_3", CTRL_DIV, 32'd20, 32'd3, 32'd6, 34, 33);
        run_op("b2b_divu_9_4", CTRL_DIVU, 32'd9, 32'd4, 32'd2, 34, 33);
        @(negedge clk);

        // Asynchronous reset ten cycles into a calculation.
        issue(CTRL_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        check("rstmid_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        watch(40, ndone, nbusy);
        check("rstmid_no_done", ndone, 0);
        check("rstmid_no_busy", nbusy, 0);

        // Non-divide opcode is ignored.
        issue(4'b0010, 32'd100, 32'd7);
        watch(40, ndone, nbusy);
        check("badop_no_done", ndone, 0);
        check("badop_no_busy", nbusy, 0);

        // A start during CALC must not disturb the in-flight operation.
        issue(CTRL_DIVU, 32'd100, 32'd7);
        ndone = 0;
        first = -1;
        seen  = '0;
        for (int n = 1; n <= 45; n++) begin
            if (n == 5) begin
                ALU_ctrl = CTRL_REMU;
                src_a    = 32'd8;
                src_b    = 32'd3;
                start    = 1'b1;
            end
            if (n == 6) start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) first = n;
                seen = result;
            end
            @(negedge clk);
        end
        check("inflight_ndone", ndone, 1);
        check("inflight_lat", first, 34);
        check("inflight_res", seen, 32'd14);

        run_op("pre_flush_remu", CTRL_REMU, 32'd100, 32'd7, 32'd2, 34, 33);
        @(negedge clk);

        // Flush with a simultaneous start: flush wins, result keeps its value.
        issue(CTRL_DIVU, 32'd100, 32'd7);
        repeat (11) @(negedge clk);
        flush    = 1'b1;
        start    = 1'b1;
        ALU_ctrl = CTRL_DIVU;
        src_a    = 32'd50;
        src_b    = 32'd5;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_done", done, 0);
        watch(40, ndone, nbusy);
        check("flush_no_done", ndone, 0);
        check("flush_no_busy", nbusy, 0);
        check("flush_result", result, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
